// File: rtl/mdio_host_sequencer_if.sv
// mdio_host_sequencer_if: host command, generator and response signals of the MDIO host sequencer
interface mdio_host_sequencer_if #(parameter int DEPTH = 4);
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [1:0]               cmd_op;
  logic [4:0]               cmd_phy;
  logic [4:0]               cmd_reg;
  logic [15:0]              cmd_wdata;
  logic                     cmd_err;
  logic                     start_stb;
  logic [31:0]              transaccion;
  logic                     mdc;
  logic                     mdio_in;
  logic                     rsp_valid;
  logic                     rsp_is_read;
  logic [15:0]              rsp_data;
  logic                     rsp_err;
  logic                     busy;
  logic [$clog2(DEPTH):0]   queue_count;
  modport slave (
    input  cmd_valid, cmd_op, cmd_phy, cmd_reg, cmd_wdata, mdc, mdio_in,
    output cmd_ready, cmd_err, start_stb, transaccion, rsp_valid, rsp_is_read, rsp_data, rsp_err, busy, queue_count
  );
  modport master (
    output cmd_valid, cmd_op, cmd_phy, cmd_reg, cmd_wdata, mdc, mdio_in,
    input  cmd_ready, cmd_err, start_stb, transaccion, rsp_valid, rsp_is_read, rsp_data, rsp_err, busy, queue_count
  );
endinterface

// File: rtl/mdio_host_sequencer.sv
// mdio_host_sequencer: queues MDIO commands, launches frames, tracks mdc and returns responses; MDIO_TIMEOUT_EN adds a RUN watchdog
module mdio_host_sequencer #(
  parameter int DEPTH       = 4,
  parameter int FRAME_MDC   = 64,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic                  clk,
  input logic                  reset,
  mdio_host_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(FRAME_MDC + 1);
  typedef enum logic [2:0] {IDLE, START, RUN, DONE, GAP} state_t;
  state_t        state_q, state_d;
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic [31:0]   tq_q, tq_d, frame;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   sh_q, sh_d, rsp_data_q, rsp_data_d;
  logic          rsp_is_read_q, rsp_is_read_d, cmd_err_q, cmd_err_d, mdc_q;
  logic          full, acc, legal, push, pop, is_read, mdc_rise, done_go, timeout;
  always_comb begin
    full      = count_q == (AW + 1)'(DEPTH);
    acc       = bus.cmd_valid & ~full;
    legal     = bus.cmd_op == 2'b01 || bus.cmd_op == 2'b10;
    push      = acc & legal;
    frame     = {2'b01, bus.cmd_op, bus.cmd_phy, bus.cmd_reg, bus.cmd_op == 2'b01 ? {2'b10, bus.cmd_wdata} : 18'h0};
    is_read   = tq_q[29:28] == 2'b10;
    mdc_rise  = bus.mdc & ~mdc_q;
    pop       = state_q == IDLE && count_q != '0;
    wptr_d    = wptr_q + AW'(push);
    rptr_d    = rptr_q + AW'(pop);
    count_d   = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
    cmd_err_d = acc & ~legal;
  end
  always_comb begin
    state_d = state_q;
    tq_d    = tq_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    case (state_q)
      IDLE: begin
        tq_d    = pop ? mem_q[rptr_q] : tq_q;
        state_d = pop ? START : IDLE;
      end
      START: begin
        cnt_d   = '0;
        sh_d    = '0;
        state_d = RUN;
      end
      RUN: begin
        cnt_d   = cnt_q + CW'(mdc_rise);
        sh_d    = mdc_rise && is_read && cnt_q >= CW'(FRAME_MDC - 16) ? {sh_q[14:0], bus.mdio_in} : sh_q;
        state_d = cnt_d == CW'(FRAME_MDC) || timeout ? DONE : RUN;
      end
      DONE:    state_d = GAP;
      GAP:     state_d = bus.mdc ? GAP : IDLE;
      default: state_d = IDLE;
    endcase
    done_go       = state_q == RUN && state_d == DONE;
    rsp_is_read_d = done_go ? is_read : rsp_is_read_q;
    rsp_data_d    = done_go ? (timeout ? 16'hFFFF : is_read ? sh_d : 16'h0) : rsp_data_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      wptr_q        <= '0;
      rptr_q        <= '0;
      count_q       <= '0;
      tq_q          <= '0;
      cnt_q         <= '0;
      sh_q          <= '0;
      rsp_data_q    <= '0;
      rsp_is_read_q <= 1'b0;
      cmd_err_q     <= 1'b0;
      mdc_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      count_q       <= count_d;
      tq_q          <= tq_d;
      cnt_q         <= cnt_d;
      sh_q          <= sh_d;
      rsp_data_q    <= rsp_data_d;
      rsp_is_read_q <= rsp_is_read_d;
      cmd_err_q     <= cmd_err_d;
      mdc_q         <= bus.mdc;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= frame;
  end
`ifdef MDIO_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] wd_q, wd_d;
  logic          rsp_err_q, rsp_err_d;
  always_comb begin
    wd_d      = state_q == RUN && !mdc_rise ? wd_q + 1'b1 : '0;
    timeout   = state_q == RUN && !mdc_rise && wd_d == TW'(TIMEOUT_CYC);
    rsp_err_d = done_go ? timeout : rsp_err_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_q      <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      rsp_err_q <= rsp_err_d;
    end
  end
  assign bus.rsp_err = rsp_err_q;
`else
  assign timeout     = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif
  assign bus.cmd_ready   = ~full;
  assign bus.cmd_err     = cmd_err_q;
  assign bus.start_stb   = state_q == START;
  assign bus.transaccion = tq_q;
  assign bus.rsp_valid   = state_q == DONE;
  assign bus.rsp_is_read = rsp_is_read_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.busy        = state_q != IDLE || count_q != '0;
  assign bus.queue_count = count_q;
endmodule

// File: doc/mdio_host_sequencer.md
Name: mdio_host_sequencer

Overview:
- Host-side command stage directly upstream of the MDIO generator (management frame serializer).
- Queues host read/write requests and builds the 32-bit `transaccion` frame word.
- Pulses `start_stb` for each frame, tracks frame progress by watching `mdc`, and captures read data from `mdio_in`.
- Returns one response per executed command.

Parameters:
- DEPTH, 4, command FIFO entries; power of 2, minimum 2.
- FRAME_MDC, 64, `mdc` rising edges per frame (32 preamble + 32 frame bits).
- TIMEOUT_CYC, 1024, `clk` cycles without an `mdc` rise before abort; used only with the optional feature.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  FIFO not full.
- cmd_op  in  2  01 = write, 10 = read; 00 and 11 are illegal.
- cmd_phy  in  5  PHY address.
- cmd_reg  in  5  register address.
- cmd_wdata  in  16  write data; ignored for reads.
- cmd_err  out  1  1-cycle pulse when an illegal op is dropped.
- start_stb  out  1  1-cycle frame start pulse to the generator.
- transaccion  out  32  frame word to the generator.
- mdc  in  1  management clock from the generator.
- mdio_in  in  1  data line returned from the PHY side.
- rsp_valid  out  1  1-cycle response pulse.
- rsp_is_read  out  1  response belongs to a read.
- rsp_data  out  16  read data; 0 for writes.
- rsp_err  out  1  response aborted (timeout).
- busy  out  1  FSM not in IDLE, or FIFO not empty.
- queue_count  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async, `reset` = 0):
  - FIFO flushed; FSM to IDLE.
  - All outputs 0, except `cmd_ready` = 1.
  - `transaccion` = 32'h0.
  - Any frame in flight is abandoned with no response.
- Enqueue:
  - A command is accepted when `cmd_valid` & `cmd_ready`.
  - `cmd_ready` = ~full.
  - An illegal op is consumed but not stored; `cmd_err` pulses on the next cycle.
- Push and pop in the same cycle: allowed.
  - `queue_count` stays unchanged.
  - When full, a pop does not raise `cmd_ready` until the next cycle.
- Frame word:
  - [31:30] = 01
  - [29:28] = op
  - [27:23] = phy
  - [22:18] = reg
  - [17:16] = 10 for a write, 00 for a read
  - [15:0] = wdata for a write, 0 for a read
- Edge detect: `mdc` is registered once; `mdc_rise` = `mdc` & ~`mdc_q`.
- FSM:
  - IDLE: if the FIFO is not empty, pop the head, latch `transaccion`, go to START.
  - START: `start_stb` = 1 for exactly one cycle; clear edge counter and shift register; go to RUN.
  - RUN:
    - Count `mdc_rise` events.
    - For a read, on each rise with index k in [FRAME_MDC-16, FRAME_MDC-1], shift `mdio_in` in, MSB first.
    - When the count reaches FRAME_MDC, go to DONE.
  - DONE:
    - `rsp_valid` = 1 for one cycle.
    - `rsp_is_read` = op==10.
    - `rsp_data` = shift register for a read, 0 for a write.
    - Go to GAP.
  - GAP: wait for `mdc` = 0, then go to IDLE. This guarantees at least one idle `mdc` low phase between frames.
- `transaccion` holds stable from START through DONE, and keeps its last value in IDLE.
- `rsp_*` outputs hold their values between pulses.
- Latency: command accepted into an empty FIFO while IDLE → `start_stb` 2 cycles later.
- Back-to-back commands are executed in FIFO order; exactly one response per legal command.

Optional Feature:
- Macro: MDIO_TIMEOUT_EN.
- Defined:
  - In RUN, a counter counts `clk` cycles since the last `mdc_rise`.
  - When it reaches TIMEOUT_CYC, go to DONE with `rsp_err` = 1 and `rsp_data` = 16'hFFFF.
  - Then proceed via GAP to IDLE.
- Undefined: no watchdog; RUN waits indefinitely; `rsp_err` tied 0.

Test Plan:
- Write op=01, phy=0x0A, reg=0x03, data=0x1234 → `transaccion` = 32'h550E1234, one `start_stb` pulse, after 64 `mdc` rises `rsp_valid` with `rsp_is_read` = 0 and `rsp_data` = 0.
- Read op=10, phy=0x01, reg=0x02 with the PHY-side model returning 0x2468 → `transaccion` = 32'h60880000, `rsp_data` = 16'h2468, `rsp_is_read` = 1.
- Push 5 commands with DEPTH=4 while busy → `cmd_ready` drops after the 4th stored entry, `queue_count` peaks at 4, and all responses arrive in order.
- Illegal op=11 → `cmd_err` pulse, no `start_stb`, `queue_count` unchanged.
- Assert `reset` = 0 mid-RUN (around `mdc` rise 30) → all outputs cleared immediately, FIFO emptied, no `rsp_valid`; the next command after release runs normally.
- With MDIO_TIMEOUT_EN and `mdc` stuck low after START → `rsp_valid` with `rsp_err` = 1 and `rsp_data` = 16'hFFFF after 1024 cycles.
